// File: rtl/alu_operand_stage_if.sv
// Request/result bundle for the ALU operand issue stage.
// The master side drives requests and consumes results; the slave side is the stage.
interface alu_operand_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             out_cin;
  logic [2:0]       out_op;
  logic             gate_en;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_cin, out_op, gate_en
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_a, out_b, out_cin, out_op, gate_en
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the carry-lookahead adder: 2-entry queue of pre-conditioned
// operands plus an idle timer that drives the result-register clock-gate enable.
module alu_operand_stage #(
  parameter int WIDTH       = 16,
  parameter int IDLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  alu_operand_stage_if.slave  bus
);

  localparam logic [3:0] IDLE_MAX = 4'(IDLE_CYCLES);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [2:0]       op;
  } entry_t;

  // SUB/INC/DEC are mapped onto a plain adder by rewriting B and carry-in.
  function automatic entry_t condition_req(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [2:0]       op);
    entry_t e;
    e.a   = a;
    e.op  = op;
    e.b   = b;
    e.cin = 1'b0;
    case (op)
      3'b001: begin e.b = ~b;              e.cin = 1'b1; end
      3'b010: begin e.b = {WIDTH{1'b0}};   e.cin = 1'b1; end
      3'b011: begin e.b = {WIDTH{1'b1}};   e.cin = 1'b0; end
      default: begin e.b = b;              e.cin = 1'b0; end
    endcase
    return e;
  endfunction

  entry_t     head_r;
  entry_t     tail_r;
  logic [1:0] count_r;
  logic [3:0] idle_cnt_r;

  logic   in_ready_s;
  logic   out_valid_s;
  logic   push_s;
  logic   pop_s;
  logic   busy_s;
  entry_t cond_s;

  // Handshake qualifiers and conditioning of the incoming request.
  always_comb begin
    in_ready_s  = (count_r != 2'd2);
    out_valid_s = (count_r != 2'd0);
    push_s      = bus.in_valid & in_ready_s;
    pop_s       = out_valid_s & bus.out_ready;
    busy_s      = bus.in_valid | out_valid_s;
    cond_s      = condition_req(bus.in_a, bus.in_b, bus.in_op);
  end

  // Queue occupancy, head/tail storage and idle timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= 2'd0;
      idle_cnt_r <= IDLE_MAX;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= cond_s;
          end else begin
            tail_r <= cond_s;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          // Head keeps its last value when draining to empty so the adder stays quiet.
          if (count_r == 2'd2) begin
            head_r <= tail_r;
          end else begin
            head_r <= head_r;
          end
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          // Only reachable at count 1: the new entry replaces the departing head.
          head_r <= cond_s;
        end
        default: begin
          head_r <= head_r;
        end
      endcase

      if (busy_s) begin
        idle_cnt_r <= 4'd0;
      end else if (idle_cnt_r != IDLE_MAX) begin
        idle_cnt_r <= idle_cnt_r + 4'd1;
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_a     = head_r.a;
  assign bus.out_b     = head_r.b;
  assign bus.out_cin   = head_r.cin;
  assign bus.out_op    = head_r.op;
  assign bus.gate_en   = busy_s | (idle_cnt_r != IDLE_MAX);

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;

  logic clk;
  logic rst;
  int   checks_s;
  int   failures_s;

  alu_operand_stage_if #(.WIDTH(16)) bus ();

  alu_operand_stage #(.WIDTH(16), .IDLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_s = checks_s + 1;
    if (obs !== exp) begin
      failures_s = failures_s + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = op;
  endtask

  task automatic check_head(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic [2:0] op);
    check({tag, ".valid"}, bus.out_valid, 1'b1);
    check({tag, ".a"},     bus.out_a,     a);
    check({tag, ".b"},     bus.out_b,     b);
    check({tag, ".cin"},   bus.out_cin,   cin);
    check({tag, ".op"},    bus.out_op,    op);
  endtask

  initial begin
    checks_s   = 0;
    failures_s = 0;
    rst        = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0000, 16'h0000, 3'b000);
    step();
    step();
    rst = 1'b0;

    // Reset state and idle period.
    for (int i = 0; i < 10; i++) begin
      check("idle.in_ready",  bus.in_ready,  1'b1);
      check("idle.out_valid", bus.out_valid, 1'b0);
      check("idle.gate_en",   bus.gate_en,   1'b0);
      check("idle.out_a",     bus.out_a,     16'h0000);
      check("idle.out_b",     bus.out_b,     16'h0000);
      check("idle.out_cin",   bus.out_cin,   1'b0);
      check("idle.out_op",    bus.out_op,    3'b000);
      step();
    end

    // SUB 5 - 3.
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h0005, 16'h0003, 3'b001);
    #1;
    check("sub.gate_same_cycle", bus.gate_en, 1'b1);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 3'b000);
    check_head("sub", 16'h0005, 16'hFFFC, 1'b1, 3'b001);
    step();
    check("sub.popped", bus.out_valid, 1'b0);
    check("sub.hold_b", bus.out_b,     16'hFFFC);

    // INC then DEC back-to-back.
    drive(1'b1, 16'h7FFF, 16'h1234, 3'b010);
    step();
    drive(1'b1, 16'h0000, 16'h4321, 3'b011);
    check_head("inc", 16'h7FFF, 16'h0000, 1'b1, 3'b010);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 3'b000);
    check_head("dec", 16'h0000, 16'hFFFF, 1'b0, 3'b011);
    step();
    check("dec.popped", bus.out_valid, 1'b0);

    // Backpressure: three pushes against a stalled consumer.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h0001, 16'h0002, 3'b000);
    step();
    check("bp.ready_after1", bus.in_ready, 1'b1);
    drive(1'b1, 16'h00F0, 16'h0FF0, 3'b100);
    step();
    check("bp.ready_after2", bus.in_ready, 1'b0);
    check_head("bp.head1", 16'h0001, 16'h0002, 1'b0, 3'b000);
    drive(1'b1, 16'hAAAA, 16'h5555, 3'b110);
    step();
    step();
    check("bp.stalled_ready", bus.in_ready, 1'b0);
    check_head("bp.stable", 16'h0001, 16'h0002, 1'b0, 3'b000);
    bus.out_ready = 1'b1;
    step();
    check("bp.ready_after_pop", bus.in_ready, 1'b1);
    check_head("bp.head2", 16'h00F0, 16'h0FF0, 1'b0, 3'b100);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 3'b000);
    check_head("bp.head3", 16'hAAAA, 16'h5555, 1'b0, 3'b110);
    step();
    check("bp.drained", bus.out_valid, 1'b0);

    // Stream of 8 ADDs at full rate.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(i * 16'h0111), 16'(16'h1000 + i), 3'b000);
      step();
      check("stream.ready", bus.in_ready, 1'b1);
      check_head("stream", 16'(i * 16'h0111), 16'(16'h1000 + i), 1'b0, 3'b000);
    end
    drive(1'b0, 16'h0000, 16'h0000, 3'b000);
    step();
    check("stream.end_valid", bus.out_valid, 1'b0);

    // Clock-gate enable stays up for exactly four idle cycles after the last pop.
    for (int i = 0; i < 4; i++) begin
      check("gate.hold", bus.gate_en, 1'b1);
      step();
    end
    check("gate.off", bus.gate_en, 1'b0);
    step();
    check("gate.still_off", bus.gate_en, 1'b0);

    // Wake-up and reset with two queued entries.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1111, 16'h2222, 3'b101);
    #1;
    check("wake.gate_same_cycle", bus.gate_en, 1'b1);
    step();
    drive(1'b1, 16'h3333, 16'h4444, 3'b111);
    step();
    drive(1'b0, 16'h0000, 16'h0000, 3'b000);
    check("rst.full_ready", bus.in_ready, 1'b0);
    check_head("rst.head", 16'h1111, 16'h2222, 1'b0, 3'b101);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst.out_valid", bus.out_valid, 1'b0);
    check("rst.in_ready",  bus.in_ready,  1'b1);
    check("rst.out_a",     bus.out_a,     16'h0000);
    check("rst.gate_en",   bus.gate_en,   1'b0);
    bus.out_ready = 1'b1;
    step();
    check("rst.entries_lost", bus.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule
